led_mode_controller: RTL and testbench
======================================

Name: led_mode_controller

Overview:
Sequences the board LED bank from one enable switch and one mode push-button on the Nexys 4 DDR. The switch and button are synchronised and debounced. A button press steps a mode FSM through OFF, STEADY, BLINK and CHASE. A prescaled tick paces the blink and chase patterns. The block sits between the raw board I/O and the LED pins as the top-level LED controller.

Parameters:
N_LED, 16, number of LED outputs driven (>= 2).
TICK_DIV, 25000000, clocks per pattern tick (>= 2); 4 Hz at 100 MHz.
DB_CYCLES, 1000000, consecutive clocks an input must differ from its stable value before it is accepted (>= 1); 10 ms at 100 MHz.
DIM_DUTY, 8, PWM on-count out of 16 (0..16); used only with LED_DIM_EN.

Ports:
CLK100MHZ  input  1  system clock, 100 MHz
CPU_RESETN  input  1  synchronous reset, active-low
SW  input  1  master enable switch, asynchronous to clock
BTNC  input  1  mode-advance button, asynchronous to clock
LED  output  N_LED  LED drive, registered
MODE  output  2  current mode: 0 OFF, 1 STEADY, 2 BLINK, 3 CHASE

Behaviour:
- Reset (CPU_RESETN=0 sampled on a CLK100MHZ rising edge): LED=0, MODE=0, all sync/debounce registers 0, counters 0, blink phase=1, chase reg=1 (bit0). Reset mid-pattern takes effect on that edge.
- Sync: SW and BTNC each pass through a 2-FF synchroniser.
- Debounce, per input:
  - Counter increments while the sync value differs from the stable value; it clears when they match.
  - When counter==DB_CYCLES-1 and the values still differ, the stable value takes the sync value and the counter clears.
- btn_pulse: one-cycle pulse on the rising edge of debounced BTNC. Releasing the button produces no pulse.
- Enable (debounced SW):
  - SW_db=0: LED=0, btn_pulse ignored, MODE held.
  - Rising SW_db restarts the current mode at its entry values and clears the tick counter.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 for one cycle when count==TICK_DIV-1. The counter clears on any mode change and while SW_db=0.
- FSM on btn_pulse with SW_db=1: OFF→STEADY→BLINK→CHASE→OFF. MODE register updates on the edge after btn_pulse.
- Mode outputs:
  - OFF: LED=0.
  - STEADY: LED=all ones.
  - BLINK: phase=1 on entry, toggles on each tick; LED={N_LED{phase}}.
  - CHASE: one-hot reg=1 on entry, rotates left on each tick; bit N_LED-1 wraps to bit0; LED=reg.
- Timing: LED is registered and lags the mode/phase/chase registers by 1 cycle.
- Simultaneous btn_pulse and tick: the mode change wins. The new mode loads its entry values and that tick is discarded.
- Simultaneous SW_db fall and btn_pulse: SW wins, MODE unchanged.

Optional Feature:
LED_DIM_EN
- Defined:
  - A free-running 4-bit PWM counter (cleared at reset) gates the lit LEDs.
  - Each LED bit = pattern bit AND (pwm_cnt < DIM_DUTY).
  - DIM_DUTY=16 gives full on; DIM_DUTY=0 gives all off.
- Undefined: no PWM counter; LED = pattern directly. DIM_DUTY is unused.

Test Plan:
All scenarios use N_LED=4, TICK_DIV=4, DB_CYCLES=3.
1. Reset: hold CPU_RESETN=0 for 3 cycles with SW=1 and BTNC=1 → LED=4'b0000, MODE=0 throughout and on the first cycle after release.
2. SW=1 settled, BTNC=1 held 10 cycles → MODE=1 exactly 7 cycles after BTNC rise (2 sync + 3 debounce + 1 edge + 1 FSM), LED=4'b1111 one cycle later; release BTNC → MODE stays 1.
3. Bounce: BTNC toggles every cycle for 12 cycles then returns to 0 → no btn_pulse, MODE unchanged.
4. Step to BLINK → LED=1111 for 4 cycles, then 0000 for 4 cycles, repeating; press in the same cycle as a tick → MODE=3, LED=0001 with no rotation that cycle.
5. CHASE → LED sequence 0001, 0010, 0100, 1000, 0001, each value held 4 cycles.
6. In CHASE at LED=0100, SW→0 → LED=0000 after sync+debounce, BTNC presses ignored, MODE=3; SW→1 → LED=0001, restarting with a full 4-cycle tick interval. With LED_DIM_EN and DIM_DUTY=8 in STEADY → each LED high exactly 8 of every 16 cycles.

Source files
------------

// File: rtl/led_mode_controller.sv
// led_mode_controller
//   Top-level LED sequencer for the Nexys 4 DDR. One enable switch and one
//   mode push-button are synchronised and debounced. Each button press steps
//   the mode through OFF -> STEADY -> BLINK -> CHASE -> OFF. A prescaled tick
//   paces the blink and chase patterns.
//
// Optional feature macro: LED_DIM_EN
//   Defined   : a free-running 4-bit PWM counter dims the lit LEDs to
//               DIM_DUTY/16 duty.
//   Undefined : LEDs show the pattern directly and DIM_DUTY is unused.
//
// Parameters
//   N_LED     : number of LED outputs (>= 2)
//   TICK_DIV  : clocks per pattern tick (>= 2)
//   DB_CYCLES : clocks an input must differ from its stable value (>= 1)
//   DIM_DUTY  : PWM on-count out of 16 (0..16), LED_DIM_EN builds only
//
// Ports
//   CLK100MHZ  in   system clock
//   CPU_RESETN in   synchronous reset, active-low
//   SW         in   master enable switch (asynchronous)
//   BTNC       in   mode-advance button (asynchronous)
//   LED        out  registered LED drive [N_LED-1:0]
//   MODE       out  current mode: 0 OFF, 1 STEADY, 2 BLINK, 3 CHASE

module led_mode_controller #(
    parameter int N_LED     = 16,
    parameter int TICK_DIV  = 25000000,
    parameter int DB_CYCLES = 1000000,
    parameter int DIM_DUTY  = 8
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             SW,
    input  logic             BTNC,
    output logic [N_LED-1:0] LED,
    output logic [1:0]       MODE
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STEADY = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    // The debounce counter only has to reach DB_CYCLES-1.
    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TICK_W = $clog2(TICK_DIV);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    if (N_LED < 2 || TICK_DIV < 2 || DB_CYCLES < 1 || DIM_DUTY < 0 || DIM_DUTY > 16)
    begin : g_param_check
        $error("led_mode_controller: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Switch: 2-FF synchroniser and debounce
    // ------------------------------------------------------------------
    logic            r_sw_meta;
    logic            r_sw_sync;
    logic [DB_W-1:0] r_sw_cnt;
    logic            r_sw_db;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_sw_meta <= 1'b0;
            r_sw_sync <= 1'b0;
            r_sw_cnt  <= '0;
            r_sw_db   <= 1'b0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            if (r_sw_sync == r_sw_db) begin
                r_sw_cnt <= '0;
            end else if (r_sw_cnt == DB_LAST) begin
                r_sw_db  <= r_sw_sync;
                r_sw_cnt <= '0;
            end else begin
                r_sw_cnt <= r_sw_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Button: 2-FF synchroniser, debounce and registered press pulse
    // ------------------------------------------------------------------
    logic            r_btn_meta;
    logic            r_btn_sync;
    logic [DB_W-1:0] r_btn_cnt;
    logic            r_btn_db;
    logic            r_btn_db_q;
    logic            r_btn_pulse;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_btn_cnt   <= '0;
            r_btn_db    <= 1'b0;
            r_btn_db_q  <= 1'b0;
            r_btn_pulse <= 1'b0;
        end else begin
            r_btn_meta <= BTNC;
            r_btn_sync <= r_btn_meta;
            if (r_btn_sync == r_btn_db) begin
                r_btn_cnt <= '0;
            end else if (r_btn_cnt == DB_LAST) begin
                r_btn_db  <= r_btn_sync;
                r_btn_cnt <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + 1'b1;
            end
            // Press only; a release gives no pulse.
            r_btn_db_q  <= r_btn_db;
            r_btn_pulse <= r_btn_db & ~r_btn_db_q;
        end
    end

    // ------------------------------------------------------------------
    // Pattern generation
    // ------------------------------------------------------------------
    mode_t             r_mode;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_phase;
    logic [N_LED-1:0]  r_chase;
    logic [N_LED-1:0]  r_led;
    logic              w_tick;
    logic [N_LED-1:0]  w_pattern;
    logic [N_LED-1:0]  w_led_next;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_pattern = '0;
        if (r_sw_db) begin
            case (r_mode)
                MODE_STEADY: w_pattern = '1;
                MODE_BLINK:  w_pattern = {N_LED{r_phase}};
                MODE_CHASE:  w_pattern = r_chase;
                default:     w_pattern = '0;
            endcase
        end
    end

`ifdef LED_DIM_EN
    localparam logic [4:0] DIM_LIM = 5'(DIM_DUTY);

    logic [3:0] r_pwm_cnt;
    logic       w_pwm_on;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_pwm_cnt <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_pwm_on   = ({1'b0, r_pwm_cnt} < DIM_LIM);
    assign w_led_next = w_pattern & {N_LED{w_pwm_on}};
`else
    assign w_led_next = w_pattern;
`endif

    // While disabled the pattern state sits at its entry values, so a rising
    // enable restarts the current mode with a full tick interval. A press
    // beats a coincident tick: the new mode loads entry values instead.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_mode     <= MODE_OFF;
            r_tick_cnt <= '0;
            r_phase    <= 1'b1;
            r_chase    <= N_LED'(1);
            r_led      <= '0;
        end else begin
            r_led <= w_led_next;
            if (!r_sw_db) begin
                r_tick_cnt <= '0;
                r_phase    <= 1'b1;
                r_chase    <= N_LED'(1);
            end else if (r_btn_pulse) begin
                case (r_mode)
                    MODE_OFF:    r_mode <= MODE_STEADY;
                    MODE_STEADY: r_mode <= MODE_BLINK;
                    MODE_BLINK:  r_mode <= MODE_CHASE;
                    default:     r_mode <= MODE_OFF;
                endcase
                r_tick_cnt <= '0;
                r_phase    <= 1'b1;
                r_chase    <= N_LED'(1);
            end else if (w_tick) begin
                r_tick_cnt <= '0;
                if (r_mode == MODE_BLINK) begin
                    r_phase <= ~r_phase;
                end
                if (r_mode == MODE_CHASE) begin
                    r_chase <= {r_chase[N_LED-2:0], r_chase[N_LED-1]};
                end
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    assign LED  = r_led;
    assign MODE = r_mode;

endmodule

// File: tb/tb_led_mode_controller.sv
module tb_led_mode_controller;

    localparam int N_LED     = 4;
    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;
    localparam int DIM_DUTY  = 8;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       sw   = 1'b0;
    logic       btn  = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    int pwm_m  = 0;

    always #5 clk = ~clk;

    led_mode_controller #(
        .N_LED    (N_LED),
        .TICK_DIV (TICK_DIV),
        .DB_CYCLES(DB_CYCLES),
        .DIM_DUTY (DIM_DUTY)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rstn),
        .SW        (sw),
        .BTNC      (btn),
        .LED       (led),
        .MODE      (mode)
    );

    // Reference PWM phase, only consulted in dimmed builds.
    always @(posedge clk) begin
        if (!rstn) pwm_m <= 0;
        else       pwm_m <= (pwm_m + 1) % 16;
    end

    // LED value expected for a given pattern, after optional dimming.
    function automatic logic [3:0] exp_led(input logic [3:0] pat);
`ifdef LED_DIM_EN
        if (((pwm_m + 15) % 16) < DIM_DUTY) return pat;
        return 4'b0000;
`else
        return pat;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sw = 1'b1; btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (led !== 4'b0000) begin
                errors++; $display("FAIL reset_led: got %b want 0000", led);
            end
            checks++;
            if (mode !== 2'd0) begin
                errors++; $display("FAIL reset_mode: got %0d want 0", mode);
            end
        end
        rstn = 1'b1;
        step();
        checks++;
        if (led !== 4'b0000 || mode !== 2'd0) begin
            errors++; $display("FAIL reset_release: led %b mode %0d want 0000 0", led, mode);
        end
        btn = 1'b0;
        repeat (10) step();
        checks++;
        if (mode !== 2'd0 || led !== exp_led(4'b0000)) begin
            errors++; $display("FAIL off_enabled: led %b mode %0d want 0000 0", led, mode);
        end
    endtask

    task automatic test_press();
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (mode !== ((i < 7) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL press_mode[%0d]: got %0d want %0d", i, mode, (i < 7) ? 0 : 1);
            end
            if (i >= 7) begin
                checks++;
                if (led !== exp_led((i == 7) ? 4'b0000 : 4'b1111)) begin
                    errors++; $display("FAIL press_led[%0d]: got %b want %b", i, led, exp_led((i == 7) ? 4'b0000 : 4'b1111));
                end
            end
        end
        btn = 1'b0;
        repeat (10) step();
        checks++;
        if (mode !== 2'd1 || led !== exp_led(4'b1111)) begin
            errors++; $display("FAIL release_steady: led %b mode %0d want 1111 1", led, mode);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 12; i++) begin
            btn = ~btn;
            step();
            checks++;
            if (mode !== 2'd1) begin
                errors++; $display("FAIL bounce_mode[%0d]: got %0d want 1", i, mode);
            end
        end
        btn = 1'b0;
        repeat (10) step();
        checks++;
        if (mode !== 2'd1 || led !== exp_led(4'b1111)) begin
            errors++; $display("FAIL bounce_after: led %b mode %0d want 1111 1", led, mode);
        end
    endtask

    // Enters BLINK, then presses so the pulse coincides with a tick.
    task automatic test_blink();
        logic [3:0] want;
        btn = 1'b1;
        repeat (7) step();
        checks++;
        if (mode !== 2'd2) begin
            errors++; $display("FAIL blink_entry: got %0d want 2", mode);
        end
        btn = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            step();
            want = ((((j - 1) / 4) % 2) == 0) ? 4'b1111 : 4'b0000;
            checks++;
            if (led !== exp_led(want)) begin
                errors++; $display("FAIL blink_led[%0d]: got %b want %b", j, led, exp_led(want));
            end
            checks++;
            if (mode !== ((j < 16) ? 2'd2 : 2'd3)) begin
                errors++; $display("FAIL blink_mode[%0d]: got %0d want %0d", j, mode, (j < 16) ? 2 : 3);
            end
            if (j == 9) btn = 1'b1;
        end
    endtask

    task automatic test_chase();
        logic [3:0] want;
        btn = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            want = 4'b0001 << (((j - 1) / 4) % 4);
            checks++;
            if (led !== exp_led(want) || mode !== 2'd3) begin
                errors++; $display("FAIL chase_led[%0d]: led %b mode %0d want %b 3", j, led, mode, exp_led(want));
            end
        end
    endtask

    task automatic test_disable();
        logic [3:0] want;
        repeat (5) step();
        checks++;
        if (led !== exp_led(4'b0100)) begin
            errors++; $display("FAIL disable_start: got %b want %b", led, exp_led(4'b0100));
        end
        sw = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            want = (k <= 3) ? 4'b0100 : (k <= 5) ? 4'b1000 : 4'b0000;
            checks++;
            if (led !== exp_led(want) || mode !== 2'd3) begin
                errors++; $display("FAIL disable_fall[%0d]: led %b mode %0d want %b 3", k, led, mode, exp_led(want));
            end
        end
        btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) btn = 1'b0;
            step();
            checks++;
            if (led !== 4'b0000 || mode !== 2'd3) begin
                errors++; $display("FAIL disabled_press[%0d]: led %b mode %0d want 0000 3", k, led, mode);
            end
        end
        sw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            want = (k <= 5) ? 4'b0000 : (k <= 9) ? 4'b0001 : 4'b0010;
            checks++;
            if (led !== exp_led(want) || mode !== 2'd3) begin
                errors++; $display("FAIL reenable[%0d]: led %b mode %0d want %b 3", k, led, mode, exp_led(want));
            end
        end
    endtask

    task automatic test_wrap_and_duty();
        int on_cnt;
        int want_on;
        btn = 1'b1; repeat (10) step();
        btn = 1'b0; repeat (10) step();
        checks++;
        if (mode !== 2'd0 || led !== exp_led(4'b0000)) begin
            errors++; $display("FAIL wrap_off: led %b mode %0d want 0000 0", led, mode);
        end
        btn = 1'b1; repeat (10) step();
        btn = 1'b0; repeat (10) step();
        checks++;
        if (mode !== 2'd1 || led !== exp_led(4'b1111)) begin
            errors++; $display("FAIL wrap_steady: led %b mode %0d want 1111 1", led, mode);
        end
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led === 4'b1111) on_cnt++;
        end
`ifdef LED_DIM_EN
        want_on = DIM_DUTY;
`else
        want_on = 16;
`endif
        checks++;
        if (on_cnt != want_on) begin
            errors++; $display("FAIL steady_duty: on %0d of 16 want %0d", on_cnt, want_on);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_blink();
        test_chase();
        test_disable();
        test_wrap_and_duty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
